// File: rtl/branch_resolve_ctrl_if.sv
// Decode-to-fetch branch bundle: op handshake from decode, resolve/redirect/flush toward fetch.
// slave = resolver side (branch_resolve_ctrl); master = decode/fetch side.
interface branch_resolve_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      func3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            resolve_valid;
  logic            resolve_taken;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            misalign_exc;

  modport slave (
    input  br_valid, is_jal, is_jalr, func3, pc, imm,
    input  rdata1, rdata2, redirect_ready,
    output br_ready, resolve_valid, resolve_taken,
    output redirect_valid, redirect_pc, flush, misalign_exc
  );

  modport master (
    output br_valid, is_jal, is_jalr, func3, pc, imm,
    output rdata1, rdata2, redirect_ready,
    input  br_ready, resolve_valid, resolve_taken,
    input  redirect_valid, redirect_pc, flush, misalign_exc
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolver: accept op, EVAL (compare + target), REDIRECT to fetch, FLUSH younger stages.
// Ports: clk, rst (sync, active-high), bus (branch_resolve_ctrl_if.slave).
// Optional BR_STATS_EN macro adds taken_cnt / not_taken_cnt outputs (32-bit, wrapping).
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_ctrl_if.slave bus
`ifdef BR_STATS_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] not_taken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REDIR,
    S_FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [2:0]      f3_q, f3_d;
  logic            jal_q, jal_d;
  logic            jalr_q, jalr_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            accept;
  logic            cond;
  logic            taken;
  logic            misal;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;

  logic            br_ready;
  logic            res_valid;
  logic            res_taken;
  logic            rdr_valid;
  logic            flush;
  logic            exc;

  assign br_ready = (state_q == S_IDLE) && !rst;
  assign accept   = bus.br_valid && br_ready;

  // Condition from captured operands; func3 010/011 fall to not-taken.
  always_comb begin
    cond = 1'b0;
    case (f3_q)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign taken    = jal_q | jalr_q | cond;
  assign jalr_sum = rs1_q + imm_q;
  assign target   = jalr_q ? {jalr_sum[XLEN-1:1], 1'b0}
                           : (pc_q + imm_q);
  assign misal    = (target[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    f3_d      = f3_q;
    jal_d     = jal_q;
    jalr_d    = jalr_q;
    rpc_d     = rpc_q;
    cnt_d     = cnt_q;
    res_valid = 1'b0;
    res_taken = 1'b0;
    rdr_valid = 1'b0;
    flush     = 1'b0;
    exc       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          pc_d    = bus.pc;
          imm_d   = bus.imm;
          rs1_d   = bus.rdata1;
          rs2_d   = bus.rdata2;
          f3_d    = bus.func3;
          jal_d   = bus.is_jal;
          jalr_d  = bus.is_jalr;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        res_valid = 1'b1;
        res_taken = taken;
        if (!taken) begin
          state_d = S_IDLE;
        end else if (misal) begin
          exc     = 1'b1;
          state_d = S_IDLE;
        end else begin
          rpc_d   = target;
          state_d = S_REDIR;
        end
      end
      S_REDIR: begin
        rdr_valid = 1'b1;
        if (bus.redirect_ready) begin
          cnt_d   = FLUSH_LOAD;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      jal_q   <= 1'b0;
      jalr_q  <= 1'b0;
      rpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      jal_q   <= jal_d;
      jalr_q  <= jalr_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by state, so they read 0 the cycle after any reset.
  assign bus.br_ready       = br_ready;
  assign bus.resolve_valid  = res_valid;
  assign bus.resolve_taken  = res_taken;
  assign bus.redirect_valid = rdr_valid;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = flush;
  assign bus.misalign_exc   = exc;

`ifdef BR_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (res_valid) begin
      if (res_taken) taken_cnt_d     = taken_cnt_q + 32'd1;
      else           not_taken_cnt_d = not_taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  branch_resolve_ctrl_if #(.XLEN(32)) bus ();

`ifdef BR_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] not_taken_cnt;
`endif

  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BR_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " br_ready"},  32'(bus.br_ready), 0);
    chk({tag, " res_valid"}, 32'(bus.resolve_valid), 0);
    chk({tag, " res_taken"}, 32'(bus.resolve_taken), 0);
    chk({tag, " rdr_valid"}, 32'(bus.redirect_valid), 0);
    chk({tag, " rdr_pc"},    bus.redirect_pc, 0);
    chk({tag, " flush"},     32'(bus.flush), 0);
    chk({tag, " misalign"},  32'(bus.misalign_exc), 0);
  endtask

  // Presents one op for a single cycle; returns at the falling edge of the EVAL cycle.
  task automatic issue(input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] p,
                       input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] r2);
    bus.br_valid = 1'b1;
    bus.is_jal   = jal;
    bus.is_jalr  = jalr;
    bus.func3    = f3;
    bus.pc       = p;
    bus.imm      = im;
    bus.rdata1   = r1;
    bus.rdata2   = r2;
    @(negedge clk);
    bus.br_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.br_valid       = 1'b0;
    bus.is_jal         = 1'b0;
    bus.is_jalr        = 1'b0;
    bus.func3          = 3'd0;
    bus.pc             = '0;
    bus.imm            = '0;
    bus.rdata1         = '0;
    bus.rdata2         = '0;
    bus.redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle ready", 32'(bus.br_ready), 1);

    // BEQ 5==5, 0x100+0x20
    issue(0, 0, 3'b000, 32'h100, 32'h20, 5, 5);
    chk("beq rv", 32'(bus.resolve_valid), 1);
    chk("beq taken", 32'(bus.resolve_taken), 1);
    chk("beq busy", 32'(bus.br_ready), 0);
    chk("beq mis", 32'(bus.misalign_exc), 0);
    @(negedge clk);
    chk("beq rdr_v", 32'(bus.redirect_valid), 1);
    chk("beq rdr_pc", bus.redirect_pc, 32'h120);
    chk("beq rv off", 32'(bus.resolve_valid), 0);
    @(negedge clk);
    chk("beq fl1", 32'(bus.flush), 1);
    chk("beq rdr off", 32'(bus.redirect_valid), 0);
    @(negedge clk);
    chk("beq fl2", 32'(bus.flush), 1);
    chk("beq fl busy", 32'(bus.br_ready), 0);
    @(negedge clk);
    chk("beq fl end", 32'(bus.flush), 0);
    chk("beq ready", 32'(bus.br_ready), 1);

    // BLT signed: -1 < 1
    issue(0, 0, 3'b100, 32'h200, 32'h8, 32'hFFFF_FFFF, 1);
    chk("blt taken", 32'(bus.resolve_taken), 1);
    @(negedge clk);
    chk("blt rdr_pc", bus.redirect_pc, 32'h208);
    repeat (3) @(negedge clk);
    chk("blt ready", 32'(bus.br_ready), 1);

    // BLTU: 0xFFFFFFFF < 1 false
    issue(0, 0, 3'b110, 32'h300, 32'h8, 32'hFFFF_FFFF, 1);
    chk("bltu rv", 32'(bus.resolve_valid), 1);
    chk("bltu taken", 32'(bus.resolve_taken), 0);
    @(negedge clk);
    chk("bltu rdr_v", 32'(bus.redirect_valid), 0);
    chk("bltu flush", 32'(bus.flush), 0);
    chk("bltu ready", 32'(bus.br_ready), 1);

    // func3 010: not taken, no exception
    issue(0, 0, 3'b010, 32'h300, 32'h2, 7, 7);
    chk("f3_010 taken", 32'(bus.resolve_taken), 0);
    chk("f3_010 mis", 32'(bus.misalign_exc), 0);
    @(negedge clk);
    chk("f3_010 ready", 32'(bus.br_ready), 1);

    // JALR 0x203+0 -> 0x202 misaligned
    issue(0, 1, 3'b000, 32'h0, 32'h0, 32'h203, 0);
    chk("jalr mis taken", 32'(bus.resolve_taken), 1);
    chk("jalr mis exc", 32'(bus.misalign_exc), 1);
    @(negedge clk);
    chk("jalr mis rdr", 32'(bus.redirect_valid), 0);
    chk("jalr mis flush", 32'(bus.flush), 0);
    chk("jalr mis exc off", 32'(bus.misalign_exc), 0);
    chk("jalr mis ready", 32'(bus.br_ready), 1);

    // JALR 0x201+3 -> 0x204
    issue(0, 1, 3'b000, 32'h0, 32'h3, 32'h201, 0);
    chk("jalr ok exc", 32'(bus.misalign_exc), 0);
    @(negedge clk);
    chk("jalr ok rdr_v", 32'(bus.redirect_valid), 1);
    chk("jalr ok rdr_pc", bus.redirect_pc, 32'h204);
    repeat (3) @(negedge clk);
    chk("jalr ok ready", 32'(bus.br_ready), 1);

    // JAL wrap: 0xFFFFFFF0+0x20 -> 0x10
    issue(1, 0, 3'b001, 32'hFFFF_FFF0, 32'h20, 3, 3);
    chk("jal wrap taken", 32'(bus.resolve_taken), 1);
    @(negedge clk);
    chk("jal wrap pc", bus.redirect_pc, 32'h10);
    repeat (3) @(negedge clk);

    // BNE with fetch stalled 5 cycles: 0x1000-4 -> 0xFFC
    bus.redirect_ready = 1'b0;
    issue(0, 0, 3'b001, 32'h1000, 32'hFFFF_FFFC, 1, 2);
    chk("bp taken", 32'(bus.resolve_taken), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rdr_v", 32'(bus.redirect_valid), 1);
      chk("bp rdr_pc", bus.redirect_pc, 32'hFFC);
      chk("bp no flush", 32'(bus.flush), 0);
    end
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk("bp flush", 32'(bus.flush), 1);
    chk("bp rdr off", 32'(bus.redirect_valid), 0);
    @(negedge clk);
    chk("bp flush2", 32'(bus.flush), 1);
    @(negedge clk);
    chk("bp ready", 32'(bus.br_ready), 1);

    // Reset during FLUSH
    issue(1, 0, 3'b000, 32'h40, 32'h8, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rstf flush", 32'(bus.flush), 1);
    rst = 1'b1;
    @(negedge clk);
    all_zero("rst_fl");
    rst = 1'b0;
    @(negedge clk);
    chk("rstf ready", 32'(bus.br_ready), 1);

    // Reset during REDIRECT, then BGE 5>=5: 0x80+0x10
    bus.redirect_ready = 1'b0;
    issue(1, 0, 3'b000, 32'h40, 32'h8, 0, 0);
    @(negedge clk);
    chk("rstr rdr_v", 32'(bus.redirect_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    all_zero("rst_rd");
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    issue(0, 0, 3'b101, 32'h80, 32'h10, 5, 5);
    chk("post rst taken", 32'(bus.resolve_taken), 1);
    @(negedge clk);
    chk("post rst pc", bus.redirect_pc, 32'h90);
    repeat (3) @(negedge clk);
    chk("post rst ready", 32'(bus.br_ready), 1);

`ifdef BR_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    chk("cnt clr t", taken_cnt, 0);
    chk("cnt clr n", not_taken_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(0, 1, 3'b000, 0, 0, 32'h203, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      issue(0, 0, 3'b000, 0, 0, 1, 2);
      @(negedge clk);
    end
    chk("cnt taken", taken_cnt, 3);
    chk("cnt not", not_taken_cnt, 2);
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.taken_cnt_q;
    issue(0, 1, 3'b000, 0, 0, 32'h203, 0);
    @(negedge clk);
    chk("cnt wrap", taken_cnt, 0);
    chk("cnt not hold", not_taken_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
